// File: rtl/seq_divider_pkg.sv
// Shared encodings and constants for the RV32M sequential divider.
package seq_divider_pkg;

    localparam int unsigned DIV_XLEN  = 32;
    localparam int unsigned DIV_CNT_W = 6;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic logic op_is_signed(input op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_divider_32_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;
    logic          w_borrow;

    assign w_rem_sh = {rem_in, quo_in[XLEN-1]};
    // rem_in < divisor keeps w_rem_sh < 2*divisor, so bit XLEN of the difference is exactly the borrow
    assign w_diff   = w_rem_sh - {1'b0, divisor};
    assign w_borrow = w_diff[XLEN];

    assign rem_out  = w_borrow ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
    assign quo_out  = {quo_in[XLEN-2:0], ~w_borrow};

endmodule

// File: rtl/seq_divider_32.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready on request and result.
// Define SEQ_DIVIDER_EARLY_EXIT_EN to skip the dividend's leading zeros before iterating.
module seq_divider_32
    import seq_divider_pkg::*;
#(
    parameter int unsigned XLEN  = DIV_XLEN,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy
);

    localparam logic [XLEN-1:0]  L_INT_MIN = XLEN'(INT_MIN);
    localparam logic [CNT_W-1:0] L_ITER    = CNT_W'(XLEN);

    state_t            r_state, w_state_nxt;
    op_t               r_op, w_op_nxt;
    logic              r_sign_a, w_sign_a_nxt;
    logic              r_sign_b, w_sign_b_nxt;
    logic [XLEN-1:0]   r_rem, w_rem_nxt;
    logic [XLEN-1:0]   r_quo, w_quo_nxt;
    logic [XLEN-1:0]   r_div, w_div_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [XLEN-1:0]   r_rsp_data, w_rsp_data_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_busy, w_busy_nxt;

    op_t               w_op;
    logic              w_sign_a, w_sign_b, w_div0, w_ovf;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic [XLEN-1:0]   w_step_rem, w_step_quo;
    logic [XLEN-1:0]   w_fix_quo, w_fix_rem;

    assign w_op     = op_t'(req_op);
    assign w_sign_a = op_is_signed(w_op) & req_a[XLEN-1];
    assign w_sign_b = op_is_signed(w_op) & req_b[XLEN-1];
    assign w_abs_a  = w_sign_a ? (~req_a + XLEN'(1)) : req_a;
    assign w_abs_b  = w_sign_b ? (~req_b + XLEN'(1)) : req_b;
    assign w_div0   = (req_b == '0);
    assign w_ovf    = op_is_signed(w_op) && (req_a == L_INT_MIN) && (req_b == '1);

    // Signs are cleared for unsigned ops and special cases, so no op check is needed here
    assign w_fix_quo = (r_sign_a ^ r_sign_b) ? (~r_quo + XLEN'(1)) : r_quo;
    assign w_fix_rem = r_sign_a ? (~r_rem + XLEN'(1)) : r_rem;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    function automatic logic [CNT_W-1:0] f_lzc(input logic [XLEN-1:0] v);
        logic [CNT_W-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = int'(XLEN) - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    logic [CNT_W-1:0] w_lz;
    assign w_lz = f_lzc(w_abs_a);
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_div),
        .rem_out (w_step_rem),
        .quo_out (w_step_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_DIV;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_sign_a    <= w_sign_a_nxt;
            r_sign_b    <= w_sign_b_nxt;
            r_rem       <= w_rem_nxt;
            r_quo       <= w_quo_nxt;
            r_div       <= w_div_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_sign_a_nxt    = r_sign_a;
        w_sign_b_nxt    = r_sign_b;
        w_rem_nxt       = r_rem;
        w_quo_nxt       = r_quo;
        w_div_nxt       = r_div;
        w_cnt_nxt       = r_cnt;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_valid_nxt = r_rsp_valid;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_op_nxt     = w_op;
                    w_sign_a_nxt = w_sign_a;
                    w_sign_b_nxt = w_sign_b;
                    w_div_nxt    = w_abs_b;
                    w_rem_nxt    = '0;
                    w_quo_nxt    = w_abs_a;
                    w_cnt_nxt    = L_ITER;
                    w_state_nxt  = CALC;
                    // Special cases preload the final quotient/remainder and only need the select in FIX
                    if (w_div0) begin
                        w_sign_a_nxt = 1'b0;
                        w_sign_b_nxt = 1'b0;
                        w_quo_nxt    = '1;
                        w_rem_nxt    = req_a;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = FIX;
                    end else if (w_ovf) begin
                        w_sign_a_nxt = 1'b0;
                        w_sign_b_nxt = 1'b0;
                        w_quo_nxt    = L_INT_MIN;
                        w_rem_nxt    = '0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = FIX;
                    end else begin
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
                        w_quo_nxt = w_abs_a << w_lz;
                        w_cnt_nxt = L_ITER - w_lz;
                        if (w_lz == L_ITER) w_state_nxt = FIX;
`endif
                    end
                end
            end
            CALC: begin
                w_rem_nxt = w_step_rem;
                w_quo_nxt = w_step_quo;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
            end
            FIX: begin
                w_rsp_data_nxt  = op_is_rem(r_op) ? w_fix_rem : w_fix_quo;
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_req_ready_nxt = (w_state_nxt == IDLE);
        w_busy_nxt      = (w_state_nxt != IDLE);
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;

endmodule
